sysbus_io_initiator: RTL and testbench

- Bus-master end of the sysbus IO channel. Accepts single read/write requests from the core's load/store path and drives sysbus_o_io_valid/write/addr/data.
- Waits for the responder's sysbus_i_io_ready, captures sysbus_i_io_data and returns a response.
- Completes the four-phase release: valid low, then wait for ready low, before the next request.
- Adds a timeout so a dead IO address cannot hang the core.

---
 rtl/sysbus_io_initiator.sv | 205 ++++++++++++++++++++
 tb/tb_sysbus_io_initiator.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_io_initiator.sv
// -----------------------------------------------------------------------------
// sysbus_io_initiator
//
// Purpose:
//   Bus-master end of the sysbus IO channel. Accepts one read or write request
//   at a time from the core load/store path and drives it onto the sysbus IO
//   request signals. It then waits for the responder's ready, captures the
//   returned data and hands a response back to the core. Before the next
//   request it completes the four-phase release: valid goes low first, then
//   the initiator waits for ready to go low. A timeout stops a dead IO address
//   from hanging the core.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles spent in REQ without ready before an error abort;
//                   0 disables the timeout
//   CNT_W           width of the timeout counter; must be able to hold
//                   TIMEOUT_CYCLES
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready    core request handshake
//   req_write/addr/wdata   request kind (1 = write), address, write data
//   resp_valid/resp_ready  core response handshake
//   resp_rdata/resp_err    captured bus read data, timeout-abort flag
//   busy                   high whenever the initiator is not idle
//   sysbus_o_io_*          bus request valid/write/addr/data (all registered)
//   sysbus_i_io_ready      responder done; stays high until valid drops
//   sysbus_i_io_data       responder read data, valid while ready is high
// -----------------------------------------------------------------------------
module sysbus_io_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // core request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    // core response
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    // sysbus IO channel
    output logic        sysbus_o_io_valid,
    output logic        sysbus_o_io_write,
    output logic [31:0] sysbus_o_io_addr,
    output logic [31:0] sysbus_o_io_data,
    input  logic        sysbus_i_io_ready,
    input  logic [31:0] sysbus_i_io_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Last counter value before the abort fires; unused when the timeout is off.
    localparam logic [CNT_W-1:0] LP_CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic             r_io_valid;
    logic             r_io_write;
    logic [31:0]      r_io_addr;
    logic [31:0]      r_io_data;
    logic             r_resp_valid;
    logic [31:0]      r_resp_rdata;
    logic             r_resp_err;

    logic             w_idle;
    logic             w_accept;
    logic             w_timeout;
    logic             w_resp_hs;
    logic             w_resp_clear;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_accept  = req_valid && w_idle;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == LP_CNT_LAST);
    assign w_resp_hs = r_resp_valid && resp_ready;
    // Response handshake is finished: either already taken, or being taken now.
    assign w_resp_clear = !r_resp_valid || resp_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of the order the always blocks evaluate in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first, so every path assigns w_state_nxt and no latch
        // is inferred.
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ready wins over the timeout when both occur in one cycle.
                if (sysbus_i_io_ready || w_timeout) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Leave only when the core has the response and the responder
                // has released ready (last phase of the four-phase handshake).
                if (w_resp_clear && !sysbus_i_io_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Bus request, response and timeout counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_io_valid   <= 1'b0;
            r_io_write   <= 1'b0;
            r_io_addr    <= '0;
            r_io_data    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_cnt        <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // Any ready seen here is a stale release and is ignored.
                    if (w_accept) begin
                        r_io_valid <= 1'b1;
                        r_io_write <= req_write;
                        r_io_addr  <= req_addr;
                        r_io_data  <= req_wdata;
                        r_cnt      <= '0;
                    end
                end
                ST_REQ: begin
                    if (sysbus_i_io_ready) begin
                        // Data is captured for writes too; the core ignores it.
                        r_resp_rdata <= sysbus_i_io_data;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_io_valid   <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_io_valid   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + LP_CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (w_resp_hs) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_io_valid   <= 1'b0;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready         = w_idle;
    assign busy              = !w_idle;
    assign resp_valid        = r_resp_valid;
    assign resp_rdata        = r_resp_rdata;
    assign resp_err          = r_resp_err;
    assign sysbus_o_io_valid = r_io_valid;
    assign sysbus_o_io_write = r_io_write;
    assign sysbus_o_io_addr  = r_io_addr;
    assign sysbus_o_io_data  = r_io_data;

endmodule

// File: tb/tb_sysbus_io_initiator.sv
// -----------------------------------------------------------------------------
// tb_sysbus_io_initiator
//
// Purpose:
//   Directed bench for sysbus_io_initiator with TIMEOUT_CYCLES = 8. A small
//   behavioural responder answers bus requests after a programmable delay and
//   holds ready for a programmable number of cycles after valid drops. The
//   expected response of every request is pushed to a queue when the request
//   is driven and popped when the DUT presents its response.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_sysbus_io_initiator;

    localparam int unsigned TO_CYCLES = 8;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        sysbus_o_io_valid;
    logic        sysbus_o_io_write;
    logic [31:0] sysbus_o_io_addr;
    logic [31:0] sysbus_o_io_data;
    logic        sysbus_i_io_ready = 1'b0;
    logic [31:0] sysbus_i_io_data  = 32'h0;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    sysbus_io_initiator #(
        .TIMEOUT_CYCLES(TO_CYCLES),
        .CNT_W         (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .busy             (busy),
        .sysbus_o_io_valid(sysbus_o_io_valid),
        .sysbus_o_io_write(sysbus_o_io_write),
        .sysbus_o_io_addr (sysbus_o_io_addr),
        .sysbus_o_io_data (sysbus_o_io_data),
        .sysbus_i_io_ready(sysbus_i_io_ready),
        .sysbus_i_io_data (sysbus_i_io_data)
    );

    always #5 clk = ~clk;

    // Responder's data for an address.
    function automatic logic [31:0] rsp_word(input logic [31:0] a);
        case (a)
            32'hfe00_0010: rsp_word = 32'h0000_1234;
            32'hfe00_0014: rsp_word = 32'h5678_0000;
            default:       rsp_word = a ^ 32'hc3c3_0000;
        endcase
    endfunction

    // Behavioural responder, acting on the falling edge.
    bit rsp_en    = 1'b0;
    int rsp_delay = 1;
    int rsp_hold  = 1;
    int rsp_wait  = 0;
    int rsp_hcnt  = 0;

    always @(negedge clk) begin
        if (!rsp_en || (!sysbus_o_io_valid && !sysbus_i_io_ready)) rsp_wait = 0;
        if (rsp_en && sysbus_o_io_valid && !sysbus_i_io_ready) begin
            rsp_wait++;
            if (rsp_wait >= rsp_delay) begin
                sysbus_i_io_ready = 1'b1;
                sysbus_i_io_data  = rsp_word(sysbus_o_io_addr);
                rsp_wait          = 0;
            end
        end else if (!sysbus_o_io_valid && sysbus_i_io_ready) begin
            if (rsp_hcnt >= rsp_hold) begin
                sysbus_i_io_ready = 1'b0;
                sysbus_i_io_data  = 32'h0bad_f00d;
                rsp_hcnt          = 0;
            end else begin
                rsp_hcnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for resp_valid; count bus-valid cycles and watch that the
    // bus fields stay at the given values while valid is high.
    task automatic wait_resp(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, output int vc);
        bit got;
        bit unstable;
        vc       = 0;
        got      = 1'b0;
        unstable = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (sysbus_o_io_valid) begin
                vc++;
                if (sysbus_o_io_addr !== addr || sysbus_o_io_write !== wr ||
                    sysbus_o_io_data !== wdata) unstable = 1'b1;
            end
            if (resp_valid) got = 1'b1;
            else tick();
        end
        check({tag, "_resp_seen"}, 32'(got), 32'd1);
        check({tag, "_bus_stable"}, 32'(unstable), 32'd0);
        check({tag, "_valid_low_at_resp"}, 32'(sysbus_o_io_valid), 32'd0);
    endtask

    // Compare the presented response with the scoreboard head.
    task automatic check_resp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, resp_rdata, e.rdata);
            check({tag, "_err"}, 32'(resp_err), 32'(e.err));
        end
    endtask

    // Wait (bounded) for req_ready; it must only come back once ready is low.
    task automatic wait_idle(input string tag, input int exp_cycles);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_idle_cycles"}, 32'(n), 32'(exp_cycles));
        check({tag, "_ready_low_at_idle"}, 32'(sysbus_i_io_ready), 32'd0);
    endtask

    // One complete transaction with an optional response stall.
    task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int exp_vc, input int stall,
                           input int exp_idle);
        int          vc;
        bit          held_bad;
        logic [31:0] first_rdata;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        if (rsp_en) sb.push_back('{rdata: rsp_word(addr), err: 1'b0});
        else        sb.push_back('{rdata: 32'h0, err: 1'b1});
        tick();
        req_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_resp(tag, wr, addr, wdata, vc);
        check({tag, "_valid_cycles"}, 32'(vc), 32'(exp_vc));
        check_resp(tag);
        first_rdata = resp_rdata;
        held_bad    = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (!resp_valid || resp_rdata !== first_rdata || req_ready) held_bad = 1'b1;
        end
        if (stall > 0) check({tag, "_held_during_stall"}, 32'(held_bad), 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_resp_taken"}, 32'(resp_valid), 32'd0);
        wait_idle(tag, exp_idle);
    endtask

    initial begin
        int vc;
        logic prev_rdy;
        bit   rose;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;

        // Reset state.
        #12;
        check("rst_io_valid", 32'(sysbus_o_io_valid), 32'd0);
        check("rst_io_write", 32'(sysbus_o_io_write), 32'd0);
        check("rst_io_addr", sysbus_o_io_addr, 32'h0);
        check("rst_io_data", sysbus_o_io_data, 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Write, responder ready one cycle after valid.
        rsp_en    = 1'b1;
        rsp_delay = 1;
        rsp_hold  = 1;
        run_txn("wr", 1'b1, 32'hfe00_0000, 32'h0000_0041, 1, 0, 1);

        // Read with a 3-cycle responder delay.
        rsp_delay = 3;
        run_txn("rd3", 1'b0, 32'hfe00_0010, 32'h0, 3, 0, 1);

        // Response stalled 5 cycles by the core.
        rsp_delay = 2;
        run_txn("stall", 1'b0, 32'hfe00_0014, 32'h0, 2, 5, 0);

        // Back-to-back reads with req_valid held and resp_ready high.
        rsp_delay  = 1;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'hfe00_0010;
        req_wdata  = 32'h0;
        sb.push_back('{rdata: rsp_word(32'hfe00_0010), err: 1'b0});
        tick();
        check("b2b_first_valid", 32'(sysbus_o_io_valid), 32'd1);
        req_addr = 32'hfe00_0014;
        sb.push_back('{rdata: rsp_word(32'hfe00_0014), err: 1'b0});
        wait_resp("b2b_first", 1'b0, 32'hfe00_0010, 32'h0, vc);
        check_resp("b2b_first");
        rose     = 1'b0;
        prev_rdy = sysbus_i_io_ready;
        for (int i = 0; i < 20 && !rose; i++) begin
            tick();
            if (sysbus_o_io_valid) begin
                rose = 1'b1;
                check("b2b_ready_low_before_rise", 32'(prev_rdy), 32'd0);
                check("b2b_second_addr", sysbus_o_io_addr, 32'hfe00_0014);
            end
            prev_rdy = sysbus_i_io_ready;
        end
        check("b2b_second_rose", 32'(rose), 32'd1);
        req_valid = 1'b0;
        wait_resp("b2b_second", 1'b0, 32'hfe00_0014, 32'h0, vc);
        check_resp("b2b_second");
        tick();
        resp_ready = 1'b0;
        check("b2b_second_taken", 32'(resp_valid), 32'd0);
        wait_idle("b2b", 1);

        // Dead address: responder never answers, timeout after 8 cycles.
        rsp_en = 1'b0;
        run_txn("tmo", 1'b0, 32'hfe00_0ff0, 32'h0, int'(TO_CYCLES), 0, 0);

        // Reset while the request is outstanding.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'hfe00_0010;
        req_wdata = 32'h0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("mid_rst_in_req", 32'(sysbus_o_io_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid_drop", 32'(sysbus_o_io_valid), 32'd0);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        rsp_en    = 1'b1;
        rsp_delay = 1;
        run_txn("post_rst", 1'b0, 32'hfe00_0010, 32'h0, 1, 0, 1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
